instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 64, meaning instruction-memory words available (power of two, >= 2).
REQ-002 Parameter BASE_ADDR, default 0, meaning byte address of word 0.
REQ-003 clk  input  1  clock; single clock domain, all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  encode request present.
REQ-006 req_ready  output  1  encoder accepts request this cycle.
REQ-007 cond  input  4  condition field.
REQ-008 op  input  2  instruction class (00 data-proc, 01 memory, 10 branch, 11 multiply-ext).
REQ-009 funct  input  6  function field.
REQ-010 rn, rd  input  4 each  register fields.
REQ-011 src2  input  12  operand-2/immediate field.
REQ-012 finish  input  1  one-cycle pulse: end of program, append halt word.
REQ-013 imem_we  output  1  instruction-memory write strobe.
REQ-014 imem_addr  output  32  byte address of write.
REQ-015 imem_wdata  output  32  encoded instruction word.
REQ-016 count  output  clog2(DEPTH)+1  words written so far.
REQ-017 err  output  1  one-cycle pulse: request rejected.
REQ-018 done  output  1  program complete, encoder idle.

Function
REQ-019 Word SHALL be {cond, op, funct, rn, rd, src2} (bits 31:28, 27:26, 25:20, 19:16, 15:12, 11:0); branch imm24 is {funct[3:0], rn, rd, src2}.
REQ-020 Handshake: transfer when req_valid & req_ready at edge N; imem_we=1 with that word during cycle N+1 only; one request per cycle sustained.
REQ-021 imem_addr SHALL be BASE_ADDR + 4*slot, slot = count before the write; count increments on each write.
REQ-022 States: RUN, HALT, DONE; reset enters RUN.
REQ-023 RUN: req_ready = (accepted words < DEPTH-1), last slot always reserved for halt word.
REQ-024 finish in RUN -> HALT; HALT writes 0xEAFFFFFE (B to self, cond AL) at next slot for one cycle, then -> DONE.
REQ-025 finish and accepted request same edge: request word written first, halt word next cycle at following slot.
REQ-026 HALT and DONE: req_ready=0; finish ignored; DONE holds done=1, imem_we=0 until reset.
REQ-027 Illegal request (see REQ-033, or op=10 with funct[5]=0): accepted (req_ready honoured), no write, count unchanged, err=1 in cycle N+1.
REQ-028 Full (DEPTH-1 words written, no finish): req_ready=0, remain RUN awaiting finish.

Reset
REQ-029 Reset SHALL force state RUN, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, err=0, done=0, req_ready=1 in following cycle.
REQ-030 Reset asserted mid-HALT or mid-write SHALL cancel pending write; no strobe in cycle after reset.

Configuration
REQ-031 Macro MUL_EXT_EN selects multiply-extension support.
REQ-032 Defined: op=11 requests encoded and written like any other class.
REQ-033 Undefined: op=11 requests illegal per REQ-027.

Structure
REQ-034 Shared package arm_pkg SHALL hold op-class constants, COND_AL, HALT_WORD, and field-position constants.
REQ-035 Combinational sub-module instr_pack SHALL pack fields and flag legality; instr_encoder holds FSM, slot counter, output registers.

Verification
REQ-036 cond=E op=00 funct=001000 rn=0 rd=2 src2=001 accepted at N -> cycle N+1 imem_we=1, addr=BASE_ADDR, wdata=0xE0802001, count->1.
REQ-037 finish with no prior requests -> one write addr=BASE_ADDR wdata=0xEAFFFFFE, then done=1, count=1.
REQ-038 op=11 request: without MUL_EXT_EN -> err pulse, no imem_we, count unchanged; with it -> written.
REQ-039 DEPTH=4, req_valid held high -> 3 writes, req_ready drops; finish -> halt at BASE_ADDR+12, done=1, count=4.
REQ-040 request and finish same edge at slot 2 -> request at BASE_ADDR+8, halt at BASE_ADDR+12 next cycle.
REQ-041 reset asserted during HALT -> no halt write, all outputs at REQ-029 values next cycle.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared instruction classes, field positions and halt word for the encoder
package arm_pkg;

    // Instruction classes carried in the op field
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    // Condition code "always"
    localparam logic [3:0] COND_AL = 4'hE;

    // Least-significant bit of each field inside the 32-bit word
    localparam int COND_LSB  = 28;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_LSB = 20;
    localparam int RN_LSB    = 16;
    localparam int RD_LSB    = 12;

    // Branch-to-self with condition AL: 0xEAFFFFFE
    localparam logic [31:0] HALT_WORD = {COND_AL, OP_BR, 6'b10_1111, 4'hF, 4'hF, 12'hFFE};

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_DONE
    } enc_state_t;

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - packs instruction fields into a word and flags legality (MUL_EXT_EN enables op=11)
import arm_pkg::*;

module instr_pack (
    input  logic [3:0]  cond,
    input  logic [1:0]  op,
    input  logic [5:0]  funct,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [11:0] src2,
    output logic [31:0] word,
    output logic        legal
);

    // Field packing; for branches the low funct bits, rn, rd and src2 form imm24
    always_comb begin
        word = (32'(cond)  << COND_LSB)  |
               (32'(op)    << OP_LSB)    |
               (32'(funct) << FUNCT_LSB) |
               (32'(rn)    << RN_LSB)    |
               (32'(rd)    << RD_LSB)    |
               32'(src2);
    end

    // Branches need funct[5] set; multiply-extension only when the feature is built in
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_DP:   legal = 1'b1;
            OP_MEM:  legal = 1'b1;
            OP_BR:   legal = funct[5];
`ifdef MUL_EXT_EN
            OP_MUL:  legal = 1'b1;
`else
            OP_MUL:  legal = 1'b0;
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes instruction requests into sequential memory writes, ends with a halt word (MUL_EXT_EN)
import arm_pkg::*;

module instr_encoder #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               cond,
    input  logic [1:0]               op,
    input  logic [5:0]               funct,
    input  logic [3:0]               rn,
    input  logic [3:0]               rd,
    input  logic [11:0]              src2,
    input  logic                     finish,
    output logic                     imem_we,
    output logic [31:0]              imem_addr,
    output logic [31:0]              imem_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err,
    output logic                     done
);

    localparam int CW = $clog2(DEPTH) + 1;
    // The last slot is kept free so the halt word always fits
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH - 1);

    enc_state_t     state_q;
    logic           we_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [CW-1:0]  count_q;
    logic           err_q;
    logic           done_q;

    logic [31:0]    pack_word;
    logic           pack_legal;
    logic           accept;
    logic [31:0]    slot_addr_d;

    instr_pack u_pack (
        .cond  (cond),
        .op    (op),
        .funct (funct),
        .rn    (rn),
        .rd    (rd),
        .src2  (src2),
        .word  (pack_word),
        .legal (pack_legal)
    );

    // Ready only while running with a free non-halt slot; next write goes to the current slot
    always_comb begin
        req_ready   = (state_q == ST_RUN) && (count_q < FULL_CNT);
        accept      = req_valid && req_ready;
        slot_addr_d = BASE_ADDR + (32'(count_q) << 2);
    end

    // Encoder FSM: strobes and error pulses last one cycle, count tracks words written
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'h0;
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        if (pack_legal) begin
                            we_q    <= 1'b1;
                            addr_q  <= slot_addr_d;
                            wdata_q <= pack_word;
                            count_q <= count_q + 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    if (finish) begin
                        state_q <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    // count_q already includes any request taken with finish
                    we_q    <= 1'b1;
                    addr_q  <= slot_addr_d;
                    wdata_q <= HALT_WORD;
                    count_q <= count_q + 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign err        = err_q;
    assign done       = done_q;

endmodule
